// File: rtl/plane_setup_seq.sv
// Plane setup: takes a triangle normal n and reference vertex v0, computes
// d = -(n . v0) with one shared multiplier over three cycles, and emits (n, d).
module plane_setup_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n_x,
    input  logic [WIDTH-1:0] n_y,
    input  logic [WIDTH-1:0] n_z,
    input  logic [WIDTH-1:0] v_x,
    input  logic [WIDTH-1:0] v_y,
    input  logic [WIDTH-1:0] v_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_nx,
    output logic [WIDTH-1:0] out_ny,
    output logic [WIDTH-1:0] out_nz,
    output logic [WIDTH-1:0] out_d,
    output logic             out_degenerate,
    output logic             out_sat
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + 2;

    // Clamp limits expressed at the width of the negated sum (AW+1 bits).
    localparam logic signed [AW:0] D_MAX = {{(AW + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW:0] D_MIN = {{(AW + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_X,
        S_MUL_Y,
        S_MUL_Z,
        S_FIN,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
    logic [WIDTH-1:0] vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
    logic signed [AW-1:0] acc_q, acc_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_nx_q, out_nx_d, out_ny_q, out_ny_d, out_nz_q, out_nz_d;
    logic [WIDTH-1:0] out_d_q, out_d_d;
    logic             out_degen_q, out_degen_d;
    logic             out_sat_q, out_sat_d;

    logic signed [WIDTH-1:0] mul_a, mul_b;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    prod_ext;
    logic signed [AW-1:0]    acc_shr;
    logic signed [AW:0]      d_full;
    logic                    accept;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
    assign accept   = in_valid && in_ready;

    // Operand select for the single shared multiplier.
    always_comb begin
        mul_a = $signed(nx_q);
        mul_b = $signed(vx_q);
        case (state_q)
            S_MUL_Y: begin
                mul_a = $signed(ny_q);
                mul_b = $signed(vy_q);
            end
            S_MUL_Z: begin
                mul_a = $signed(nz_q);
                mul_b = $signed(vz_q);
            end
            default: ;
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
    assign acc_shr  = acc_q >>> FRAC;
    assign d_full   = -{acc_shr[AW-1], acc_shr};

    always_comb begin
        state_d     = state_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        nz_d        = nz_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        vz_d        = vz_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_nx_d    = out_nx_q;
        out_ny_d    = out_ny_q;
        out_nz_d    = out_nz_q;
        out_d_d     = out_d_q;
        out_degen_d = out_degen_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            S_IDLE: ;
            S_MUL_X: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_MUL_Y;
            end
            S_MUL_Y: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_MUL_Z;
            end
            S_MUL_Z: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_FIN;
            end
            S_FIN: begin
                if (d_full > D_MAX) begin
                    out_d_d   = {1'b0, {(WIDTH - 1){1'b1}}};
                    out_sat_d = 1'b1;
                end else if (d_full < D_MIN) begin
                    out_d_d   = {1'b1, {(WIDTH - 1){1'b0}}};
                    out_sat_d = 1'b1;
                end else begin
                    out_d_d   = d_full[WIDTH-1:0];
                    out_sat_d = 1'b0;
                end
                out_nx_d    = nx_q;
                out_ny_d    = ny_q;
                out_nz_d    = nz_q;
                out_degen_d = ((nx_q | ny_q | nz_q) == '0);
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                // Data registers keep their last value after the result leaves.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new operand set may be taken from IDLE or on the same edge the result leaves.
        if (accept) begin
            nx_d    = n_x;
            ny_d    = n_y;
            nz_d    = n_z;
            vx_d    = v_x;
            vy_d    = v_y;
            vz_d    = v_z;
            acc_d   = '0;
            state_d = S_MUL_X;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            nx_q        <= '0;
            ny_q        <= '0;
            nz_q        <= '0;
            vx_q        <= '0;
            vy_q        <= '0;
            vz_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_nx_q    <= '0;
            out_ny_q    <= '0;
            out_nz_q    <= '0;
            out_d_q     <= '0;
            out_degen_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            nz_q        <= nz_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            vz_q        <= vz_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_nx_q    <= out_nx_d;
            out_ny_q    <= out_ny_d;
            out_nz_q    <= out_nz_d;
            out_d_q     <= out_d_d;
            out_degen_q <= out_degen_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_nx         = out_nx_q;
    assign out_ny         = out_ny_q;
    assign out_nz         = out_nz_q;
    assign out_d          = out_d_q;
    assign out_degenerate = out_degen_q;
    assign out_sat        = out_sat_q;

endmodule

// File: tb/tb_plane_setup_seq.sv
// Bench for plane_setup_seq: directed vector table, random operands against a
// wide-arithmetic plane model, and hand sequences for backpressure and reset.
module tb_plane_setup_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] n_x, n_y, n_z, v_x, v_y, v_z;
    logic [31:0] out_nx, out_ny, out_nz, out_d;
    logic        out_degenerate, out_sat;

    int n_checks = 0;
    int n_fail   = 0;

    plane_setup_seq #(.WIDTH(32), .FRAC(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .n_x(n_x), .n_y(n_y), .n_z(n_z),
        .v_x(v_x), .v_y(v_y), .v_z(v_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_nx(out_nx), .out_ny(out_ny), .out_nz(out_nz),
        .out_d(out_d), .out_degenerate(out_degenerate), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] nx, ny, nz, vx, vy, vz;
        logic [31:0] d;
        logic        sat, dg;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plane offset from the dot product in wide integer arithmetic.
    function automatic void model(input logic [31:0] nx, ny, nz, vx, vy, vz,
                                  output logic [31:0] d, output logic sat, output logic dg);
        logic signed [127:0] a1, a2, a3, b1, b2, b3, dot, s, nd;
        a1 = $signed(nx); a2 = $signed(ny); a3 = $signed(nz);
        b1 = $signed(vx); b2 = $signed(vy); b3 = $signed(vz);
        dot = a1 * b1 + a2 * b2 + a3 * b3;
        s   = dot >>> 16;
        nd  = -s;
        if (nd > 128'sd2147483647) begin
            d = 32'h7FFF_FFFF; sat = 1'b1;
        end else if (nd < -128'sd2147483648) begin
            d = 32'h8000_0000; sat = 1'b1;
        end else begin
            d = nd[31:0]; sat = 1'b0;
        end
        dg = (nx == 0) && (ny == 0) && (nz == 0);
    endfunction

    task automatic drive(input logic [31:0] nx, ny, nz, vx, vy, vz);
        n_x = nx; n_y = ny; n_z = nz; v_x = vx; v_y = vy; v_z = vz;
    endtask

    task automatic scramble();
        drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    // Count edges from acceptance until out_valid rises (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_d"}, out_d, v.d);
        check({tag, "_sat"}, out_sat, v.sat);
        check({tag, "_degen"}, out_degenerate, v.dg);
        check({tag, "_n"}, {out_nx, out_ny, out_nz}, {v.nx, v.ny, v.nz});
    endtask

    // One full transaction from IDLE, with optional backpressure cycles in OUT.
    task automatic do_txn(input string tag, input vec_t v, input int hold);
        int cnt;
        out_ready = (hold == 0);
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        drive(v.nx, v.ny, v.nz, v.vx, v.vy, v.vz);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        wait_valid(cnt);
        check({tag, "_latency"}, cnt, 4);
        check_result(tag, v);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {out_valid, in_ready, out_d}, {1'b1, 1'b0, v.d});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_drain"}, out_valid, 0);
        $display("txn %s n=(%h,%h,%h) v=(%h,%h,%h) d=%h sat=%0b degen=%0b lat=%0d",
                 tag, v.nx, v.ny, v.nz, v.vx, v.vy, v.vz, out_d, out_sat, out_degenerate, cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_data"}, {out_nx, out_ny, out_nz, out_d}, 128'h0);
        check({tag, "_flags"}, {out_sat, out_degenerate}, 2'b00);
    endtask

    function automatic logic [31:0] rnd_val();
        if ($urandom_range(0, 1) == 0) return $urandom;
        return 32'($signed($urandom_range(0, 32'h1F_FFFF)) - 32'sh10_0000);
    endfunction

    vec_t tbl[8];
    vec_t rv, b2;

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");

        tbl[0] = '{32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0005_0000, 32'hFFFB_0000, 1'b0, 1'b0};
        tbl[1] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                   32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'hFFE0_0000, 1'b0, 1'b0};
        tbl[2] = '{32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 1'b0};
        tbl[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0};
        tbl[6] = '{32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h8765_4321, 32'h7FFF_0000, 32'h0, 1'b0, 1'b1};
        // -(1.0*-3.0) = 3.0 via one negative component
        tbl[7] = '{32'h0001_0000, 32'h0, 32'h0, 32'hFFFD_0000, 32'h0, 32'h0, 32'h0003_0000, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) do_txn($sformatf("vec%0d", i), tbl[i], 0);

        for (int i = 0; i < 30; i++) begin
            rv.nx = rnd_val(); rv.ny = rnd_val(); rv.nz = rnd_val();
            rv.vx = rnd_val(); rv.vy = rnd_val(); rv.vz = rnd_val();
            if (i % 10 == 9) begin rv.nx = 0; rv.ny = 0; rv.nz = 0; end
            model(rv.nx, rv.ny, rv.nz, rv.vx, rv.vy, rv.vz, rv.d, rv.sat, rv.dg);
            do_txn($sformatf("rnd%0d", i), rv, $urandom_range(0, 3));
        end

        // Backpressure for 6 cycles, then release with a new input on the same edge.
        out_ready = 1'b0;
        drive(tbl[1].nx, tbl[1].ny, tbl[1].nz, tbl[1].vx, tbl[1].vy, tbl[1].vz);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        wait_valid(lat);
        check("bp_latency", lat, 4);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {out_valid, in_ready, out_d, out_nz}, {1'b1, 1'b0, 32'hFFE0_0000, 32'h0003_0000});
        end
        b2 = tbl[7];
        drive(b2.nx, b2.ny, b2.nz, b2.vx, b2.vy, b2.vz);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        check("b2b_valid_drop", out_valid, 0);
        wait_valid(lat);
        check("b2b_latency", lat, 4);
        check_result("b2b", b2);
        @(posedge clk); #1;
        $display("txn backpressure+b2b d=%h lat=%0d", out_d, lat);

        // Reset while in MUL_Y.
        drive(tbl[1].nx, tbl[1].ny, tbl[1].nz, tbl[1].vx, tbl[1].vy, tbl[1].vz);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("rst_mul");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("rst_mul_no_stale", out_valid, 0);
        end
        $display("txn reset_in_mul out_valid=%0b", out_valid);

        // Reset while holding a result in OUT.
        out_ready = 1'b0;
        drive(tbl[4].nx, tbl[4].ny, tbl[4].nz, tbl[4].vx, tbl[4].vy, tbl[4].vz);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("rst_out_pending", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("rst_out");
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("rst_out_no_stale", out_valid, 0);
        end
        $display("txn reset_in_out out_valid=%0b", out_valid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
